// File: rtl/input_scan_ctrl.sv
// 4x4 keypad scanner: walks one-hot-low row drive, debounces whole-matrix frames,
// and hands single-key press events to a consumer through a valid/ack handshake.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | no press event pending, o_valid=0
// ST_PEND | press event held in o_code until acknowledged
module input_scan_ctrl #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_h,
  output logic [3:0]  o_v,
  input  logic        i_ack,
  output logic [15:0] o_key,
  output logic [3:0]  o_code,
  output logic        o_valid,
  output logic        o_overrun
);

  localparam logic [15:0] DIV_TC = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB    = 4'(DEBOUNCE);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  logic [1:0]  r_row;
  logic [15:0] r_div;
  logic [3:0]  r_v;
  logic [15:0] r_frame;
  logic        r_frame_done;
  logic [15:0] r_prev;
  logic [3:0]  r_stable;
  logic [15:0] r_key;
  state_t      r_state;
  logic [3:0]  r_code;
  logic        r_overrun;

  logic [1:0]  w_row_nxt;
  logic        w_same;
  logic [3:0]  w_stable_nxt;
  logic        w_commit;
  logic        w_event;
  logic [3:0]  w_idx;
  state_t      w_state_nxt;
  logic [3:0]  w_code_nxt;
  logic        w_overrun_nxt;

  assign w_row_nxt = r_row + 2'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row        <= 2'd0;
      r_div        <= 16'd0;
      r_v          <= 4'b1110;
      r_frame      <= 16'h0000;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_div == DIV_TC) begin
        r_div                       <= 16'd0;
        r_row                       <= w_row_nxt;
        r_v                         <= ~(4'b0001 << w_row_nxt);
        r_frame[{r_row, 2'b00} +: 4] <= ~i_h;
        r_frame_done                <= (r_row == 2'd3);
      end else begin
        r_div <= r_div + 16'd1;
      end
    end
  end

  // A frame only commits once it has repeated DEBOUNCE times in a row.
  assign w_same       = (r_frame == r_prev);
  assign w_stable_nxt = !w_same ? 4'd1 :
                        (r_stable >= DEB) ? DEB : r_stable + 4'd1;
  assign w_commit     = r_frame_done && (w_stable_nxt == DEB) && (r_frame != r_key);
  assign w_event      = w_commit && $onehot(r_frame) && ((r_frame & ~r_key) != 16'h0000);

  always_comb begin
    w_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_frame[i]) w_idx = 4'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev   <= 16'h0000;
      r_stable <= 4'd0;
      r_key    <= 16'h0000;
    end else if (r_frame_done) begin
      if (!w_same) r_prev <= r_frame;
      r_stable <= w_stable_nxt;
      if (w_commit) r_key <= r_frame;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_code    <= 4'd0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // A fresh event beats a coincident ack; an unacked event in PEND is dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_overrun_nxt = r_overrun;
    case (r_state)
      ST_IDLE: begin
        if (w_event) begin
          w_state_nxt = ST_PEND;
          w_code_nxt  = w_idx;
        end
      end
      ST_PEND: begin
        if (w_event) begin
          if (i_ack) w_code_nxt    = w_idx;
          else       w_overrun_nxt = 1'b1;
        end else if (i_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_v       = r_v;
  assign o_key     = r_key;
  assign o_code    = r_code;
  assign o_valid   = (r_state == ST_PEND);
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_input_scan_ctrl.sv
// Bench for input_scan_ctrl: keypad and consumer are emulated, every cycle is
// compared against a time-indexed reference model of the scan/debounce/handshake rules.
module tb_input_scan_ctrl;

  localparam int S   = 4;
  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack = 1'b0;
  logic [3:0]  h = 4'hF;
  logic [3:0]  v;
  logic [15:0] key;
  logic [3:0]  code;
  logic        valid;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  int unsigned cyc = 0;
  logic [15:0] m_frame = '0, m_prev = '0, m_key = '0;
  int          m_stable = 0;
  bit          m_fd = 0, m_valid = 0, m_ovr = 0;
  logic [3:0]  m_code = '0;

  logic [15:0] pressed = '0;
  int          ack_prob = 0;
  bit          ack_on_event = 0;
  int          dut_ev = 0;
  bit          last_valid = 0;

  input_scan_ctrl #(.SCAN_DIV(S), .DEBOUNCE(DEB)) dut (
    .i_clk(clk), .i_rst(rst), .i_h(h), .o_v(v), .i_ack(ack),
    .o_key(key), .o_code(code), .o_valid(valid), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive the keypad for the row the model expects, advance the model, compare.
  task automatic step();
    int row, nst, idx;
    bit upd, ev;
    logic [3:0] exp_v;
    row = (cyc / S) % 4;
    h = ~pressed[row*4 +: 4];
    upd = 0; ev = 0; nst = m_stable; idx = 0;
    if (m_fd && !rst) begin
      if (m_frame == m_prev) nst = (m_stable >= DEB) ? DEB : m_stable + 1;
      else                   nst = 1;
      upd = (nst == DEB) && (m_frame != m_key);
      ev  = upd && ($countones(m_frame) == 1) && ((m_frame & ~m_key) != 16'h0);
    end
    if (ack_on_event)   ack = ev;
    else if (ack_prob > 0) ack = ($urandom_range(0, 99) < ack_prob);
    @(posedge clk);
    if (rst) begin
      cyc = 0; m_frame = '0; m_prev = '0; m_stable = 0; m_key = '0;
      m_valid = 0; m_code = '0; m_ovr = 0; m_fd = 0;
    end else begin
      if (m_fd) begin
        if (m_frame != m_prev) m_prev = m_frame;
        m_stable = nst;
        if (upd) m_key = m_frame;
      end
      if (ev) for (int i = 0; i < 16; i++) if (m_frame[i]) idx = i;
      if (!m_valid) begin
        if (ev) begin m_valid = 1; m_code = 4'(idx); end
      end else if (ev) begin
        if (ack) m_code = 4'(idx);
        else     m_ovr = 1;
      end else if (ack) begin
        m_valid = 0;
      end
      m_fd = 0;
      cyc++;
      if (cyc % S == 0) begin
        row = ((cyc / S) - 1) % 4;
        m_frame[row*4 +: 4] = ~h;
        if (row == 3) m_fd = 1;
      end
    end
    #1;
    exp_v = ~(4'b0001 << ((cyc / S) % 4));
    check("v", {12'h0, v}, {12'h0, exp_v});
    check("key", key, m_key);
    check("code", {12'h0, code}, {12'h0, m_code});
    check("valid", {15'h0, valid}, {15'h0, m_valid});
    check("overrun", {15'h0, overrun}, {15'h0, m_ovr});
    if (valid && !last_valid) dut_ev++;
    last_valid = valid;
  endtask

  task automatic run_frames(input int n);
    repeat (n * 4 * S) step();
  endtask

  task automatic align();
    for (int i = 0; i < 4 * S && (cyc % (4 * S)) != 0; i++) step();
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    int a, b;
    do_reset();
    check("rst_v", {12'h0, v}, 16'h000E);
    check("rst_key", key, 16'h0000);

    // idle scan, nothing pressed
    run_frames(3);
    check("idle_key", key, 16'h0000);
    check("idle_valid", {15'h0, valid}, 16'h0000);

    // single key row 1 col 2
    pressed = 16'h0040;
    run_frames(3);
    check("k6_key", key, 16'h0040);
    check("k6_valid", {15'h0, valid}, 16'h0001);
    check("k6_code", {12'h0, code}, 16'h0006);
    pulse_ack();
    check("k6_ack", {15'h0, valid}, 16'h0000);
    pressed = 16'h0000;
    run_frames(3);
    check("rel_key", key, 16'h0000);
    check("rel_valid", {15'h0, valid}, 16'h0000);

    // bounce: alternating frames never commit
    align();
    dut_ev = 0;
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      run_frames(1);
    end
    check("bounce_key", key, 16'h0000);
    pressed = 16'h0040;
    run_frames(3);
    check("bounce_commit", key, 16'h0040);
    check("bounce_events", 16'(dut_ev), 16'h0001);
    pulse_ack();
    pressed = 16'h0000;
    run_frames(3);

    // overrun: key 6 unacked, brief 6+9, then 9 alone
    align();
    pressed = 16'h0040;
    run_frames(3);
    check("ovr_first", {12'h0, code}, 16'h0006);
    pressed = 16'h0240;
    run_frames(1);
    pressed = 16'h0200;
    run_frames(3);
    check("ovr_flag", {15'h0, overrun}, 16'h0001);
    check("ovr_code", {12'h0, code}, 16'h0006);
    check("ovr_key", key, 16'h0200);

    // event coincident with ack in PEND
    pressed = 16'h0000;
    do_reset();
    pressed = 16'h0008;
    run_frames(3);
    check("same_first", {12'h0, code}, 16'h0003);
    pressed = 16'h0000;
    run_frames(3);
    ack_on_event = 1;
    pressed = 16'h0020;
    run_frames(3);
    ack_on_event = 0;
    ack = 1'b0;
    check("same_valid", {15'h0, valid}, 16'h0001);
    check("same_code", {12'h0, code}, 16'h0005);
    check("same_ovr", {15'h0, overrun}, 16'h0000);

    // reset while pending at row 2
    for (int i = 0; i < 4 * S && ((cyc / S) % 4) != 2; i++) step();
    check("pre_rst_v", {12'h0, v}, 16'h000B);
    check("pre_rst_valid", {15'h0, valid}, 16'h0001);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_v", {12'h0, v}, 16'h000E);
    check("mid_rst_valid", {15'h0, valid}, 16'h0000);
    check("mid_rst_key", key, 16'h0000);
    run_frames(3);

    // randomized patterns with random acks and occasional reset
    ack_prob = 30;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: pressed = 16'h0000;
        1: pressed = 16'h0001 << $urandom_range(0, 15);
        2: begin
          a = $urandom_range(0, 15);
          b = (a + 1 + $urandom_range(0, 14)) % 16;
          pressed = (16'h0001 << a) | (16'h0001 << b);
        end
        default: ;
      endcase
      repeat ($urandom_range(1, 12 * S)) step();
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
    end
    ack_prob = 0;
    ack = 1'b0;
    run_frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
